// File: rtl/lcd_responder_if.sv
// Host-side character LCD bus: strobed data/rs/rw/en from the host, read data back.
interface lcd_responder_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_q;

    modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en, input lcd_q);
    modport slave  (input lcd_data, input lcd_rs, input lcd_rw, input lcd_en, output lcd_q);
endinterface

// File: rtl/lcd_responder.sv
// HD44780-style character LCD responder: captures enable falling edges, decodes
// instructions and data writes into a 2x16 DDRAM image, models busy timing and
// services busy-flag / DDRAM reads.
module lcd_responder #(
    parameter int CMD_CYCLES   = 4,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    lcd_responder_if.slave    bus,
    input  logic [4:0]        rd_addr,
    output logic [7:0]        rd_char,
    output logic              busy,
    output logic              overrun,
    output logic              display_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              incr,
    output logic              two_line
);

    logic [7:0]  ddram_r [32];
    logic [6:0]  ac_r;
    logic [15:0] busy_cnt_r;
    logic        en_q_r;
    logic [7:0]  q_r;
    logic        overrun_r;
    logic        display_on_r;
    logic        cursor_on_r;
    logic        blink_on_r;
    logic        incr_r;
    logic        two_line_r;

    logic        strobe_s;
    logic        busy_s;
    logic [4:0]  ac_idx_s;
    logic [7:0]  q_next_s;

    // Address counter step: wraps between the two 16-entry lines.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
        logic [6:0] nxt;
        if (up) begin
            if (ac == 7'h0F)      nxt = 7'h40;
            else if (ac == 7'h4F) nxt = 7'h00;
            else                  nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h40)      nxt = 7'h0F;
            else if (ac == 7'h00) nxt = 7'h4F;
            else                  nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // Strobe detect, busy flag, DDRAM index of AC and next read-data value.
    always_comb begin
        strobe_s = en_q_r & ~bus.lcd_en;
        busy_s   = (busy_cnt_r != 16'd0);
        ac_idx_s = {ac_r[6], ac_r[3:0]};
        q_next_s = 8'h00;
        if (bus.lcd_en && bus.lcd_rw) begin
            if (bus.lcd_rs) q_next_s = ddram_r[ac_idx_s];
            else            q_next_s = {busy_s, ac_r};
        end else begin
            q_next_s = 8'h00;
        end
    end

    // Access decode, DDRAM/AC/mode state, busy counter and registered read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) ddram_r[i] <= 8'h20;
            ac_r         <= 7'h00;
            busy_cnt_r   <= 16'd0;
            en_q_r       <= 1'b0;
            q_r          <= 8'h00;
            overrun_r    <= 1'b0;
            display_on_r <= 1'b0;
            cursor_on_r  <= 1'b0;
            blink_on_r   <= 1'b0;
            incr_r       <= 1'b1;
            two_line_r   <= 1'b0;
        end else begin
            en_q_r <= bus.lcd_en;
            q_r    <= q_next_s;
            if (busy_s) busy_cnt_r <= busy_cnt_r - 16'd1;
            else        busy_cnt_r <= busy_cnt_r;

            if (strobe_s) begin
                if (bus.lcd_rw) begin
                    // Reads ignore busy; only a DDRAM read moves AC.
                    if (bus.lcd_rs) ac_r <= ac_step(ac_r, incr_r);
                    else            ac_r <= ac_r;
                end else if (busy_s) begin
                    overrun_r <= 1'b1;
                end else if (bus.lcd_rs) begin
                    ddram_r[ac_idx_s] <= bus.lcd_data;
                    ac_r              <= ac_step(ac_r, incr_r);
                    busy_cnt_r        <= 16'(CMD_CYCLES);
                end else begin
                    // Later assignments override this for clear/home.
                    busy_cnt_r <= 16'(CMD_CYCLES);
                    casez (bus.lcd_data)
                        8'b1???????: ac_r <= {bus.lcd_data[6], 2'b00, bus.lcd_data[3:0]};
                        8'b01??????: ac_r <= ac_r;
                        8'b001?????: two_line_r <= bus.lcd_data[3];
                        8'b0001????: begin
                            if (!bus.lcd_data[3]) ac_r <= ac_step(ac_r, bus.lcd_data[2]);
                            else                  ac_r <= ac_r;
                        end
                        8'b00001???: begin
                            display_on_r <= bus.lcd_data[2];
                            cursor_on_r  <= bus.lcd_data[1];
                            blink_on_r   <= bus.lcd_data[0];
                        end
                        8'b000001??: incr_r <= bus.lcd_data[1];
                        8'b0000001?: begin
                            ac_r       <= 7'h00;
                            busy_cnt_r <= 16'(CLEAR_CYCLES);
                        end
                        8'b00000001: begin
                            for (int i = 0; i < 32; i++) ddram_r[i] <= 8'h20;
                            ac_r       <= 7'h00;
                            incr_r     <= 1'b1;
                            busy_cnt_r <= 16'(CLEAR_CYCLES);
                        end
                        default: ac_r <= ac_r;
                    endcase
                end
            end
        end
    end

    assign bus.lcd_q  = q_r;
    assign rd_char    = ddram_r[rd_addr];
    assign busy       = busy_s;
    assign overrun    = overrun_r;
    assign display_on = display_on_r;
    assign cursor_on  = cursor_on_r;
    assign blink_on   = blink_on_r;
    assign incr       = incr_r;
    assign two_line   = two_line_r;

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable model of the HD44780-style character LCD module that sits on the far end of the `lcd_data`/`lcd_rs`/`lcd_rw`/`lcd_en` bus driven by our LCD write controller. It captures each enable strobe, decodes instructions and data writes into a 2×16 DDRAM image, and models busy timing. It also services busy-flag and DDRAM reads. It serves as the in-system display stand-in and as the checker endpoint for controller and sequencer benches.

## Interface
- `CMD_CYCLES`, default 4: busy duration after any accepted access other than clear/home.
- `CLEAR_CYCLES`, default 64: busy duration after clear display (0x01) or return home (0x02/0x03).
- `clock` input 1: system clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `lcd_data` input 8: bus data from the host.
- `lcd_rs` input 1: 0 = instruction/status, 1 = DDRAM data.
- `lcd_rw` input 1: 0 = write, 1 = read.
- `lcd_en` input 1: enable strobe; the access completes on its falling edge.
- `lcd_q` output 8: read data, valid while `lcd_en`=1 and `lcd_rw`=1; 0x00 otherwise.
- `rd_addr` input 5: debug DDRAM index (0-15 line 1, 16-31 line 2).
- `rd_char` output 8: combinational DDRAM[`rd_addr`].
- `busy` output 1: busy flag.
- `overrun` output 1: sticky; set when a write strobe lands while busy.
- `display_on`, `cursor_on`, `blink_on`, `incr`, `two_line` outputs 1 each: decoded mode bits.

## Operation
- Falling-edge detect: `en_q` registers `lcd_en`. A strobe is an edge where `en_q`=1 and `lcd_en`=0. `lcd_data`/`lcd_rs`/`lcd_rw` are sampled in that cycle.
- Address counter AC is 7 bits. The legal values are 0x00-0x0F and 0x40-0x4F. The DDRAM index is {AC[6], AC[3:0]}.
- AC step on increment: 0x0F→0x40, 0x4F→0x00, otherwise +1. On decrement: 0x40→0x0F, 0x00→0x4F, otherwise −1.
- Write strobe when `busy`=0 decodes by highest set bit of the instruction (rs=0):
  - 0x01 clear: all DDRAM ← 0x20, AC ← 0, `incr` ← 1; busy CLEAR_CYCLES.
  - 0x02/0x03 home: AC ← 0; busy CLEAR_CYCLES.
  - 0x04-0x07 entry mode: `incr` ← bit1; shift bit ignored.
  - 0x08-0x0F display control: `display_on`/`cursor_on`/`blink_on` ← bits 2/1/0.
  - 0x10-0x1F cursor shift: if bit3=0, step AC by bit2 (1 = increment). Display shift is ignored.
  - 0x20-0x3F function set: `two_line` ← bit3.
  - 0x40-0x7F CGRAM address: accepted, no effect.
  - 0x80-0xFF set DDRAM address: AC ← {d[6], 2'b00, d[3:0]}.
  - All accepted instructions other than clear/home set busy for CMD_CYCLES.
- Data write (rs=1) when `busy`=0: DDRAM[AC] ← data, then AC steps per `incr`; busy for CMD_CYCLES.
- Write strobe while `busy`=1: discarded, with no state change except `overrun` ← 1. `overrun` clears only on reset.
- Reads (rw=1) are accepted regardless of busy, do not set busy, and never set `overrun`.
  - rs=0: `lcd_q` = {busy, AC}.
  - rs=1: `lcd_q` = DDRAM[AC]; on the strobe, AC steps per `incr`.
- Busy counter: loaded with N on an accepted write strobe. `busy` = (counter ≠ 0); the counter decrements each cycle.

## Timing
- Reset values (async):
  - DDRAM all 0x20, AC = 0, counter = 0, `en_q` = 0.
  - `busy` = 0, `overrun` = 0, `lcd_q` = 0x00.
  - `display_on` = `cursor_on` = `blink_on` = 0, `incr` = 1, `two_line` = 0.
- Strobe at edge k (the first edge that samples `lcd_en`=0): updates are visible after edge k. `busy`=1 from edge k for exactly N cycles, falling after edge k+N.
- A strobe arriving the cycle `busy` reads 0 is accepted.
- Minimum `lcd_en` high width is 1 clock. A high pulse shorter than one clock period may be missed.
- `lcd_q` is registered from `lcd_en`/`lcd_rw`/`lcd_rs` with 1-cycle latency while `lcd_en`=1.
- Reset mid-busy: busy clears immediately, and any in-flight strobe is lost.
- `rd_char` has zero latency and reflects a write in the cycle after the strobe.

## Test plan
- Reset, then write 0x38, 0x0C, 0x06, 0x01 with ≥70-cycle gaps.
  - Required: `two_line`=1, `display_on`=1, `cursor_on`=0, `incr`=1.
  - Required: all `rd_char`=0x20, and `busy` high for exactly 64 cycles after the clear strobe.
- Set AC 0x8E, write data 'A','B','C'.
  - Required: `rd_char`[14]=0x41, [15]=0x42, [16]=0x43.
  - Required: status read returns 0x41.
- Write 0x04 (decrement), set AC 0x80, write 'Z'.
  - Required: DDRAM[0]=0x5A, AC=0x4F.
- Issue a second data write 2 cycles after an accepted write (CMD_CYCLES=4).
  - Required: the second write is dropped, `overrun`=1, and DDRAM is unchanged at the second AC.
- Read status mid-busy.
  - Required: `lcd_q`[7]=1 with AC unchanged; a DDRAM read returns the stored char and advances AC.
- Assert `reset_n`=0 during CLEAR_CYCLES busy.
  - Required: `busy`=0 immediately, all outputs at their reset values.
